im_multiport_loadable: RTL

Parametrised multi-core instruction memory. NUM_C independent 1-cycle synchronous fetch ports share one program store. The store is cleared to a fill word on reset and loaded at runtime through a streaming valid/ready loader. Replaces hard-coded program images with a host-loadable store that the core array fetches from once mem_ready is high.

---
 rtl/im_multiport_loadable_if.sv | 31 +++
 rtl/im_multiport_loadable.sv | 128 ++++++++++++
 2 files changed

// File: rtl/im_multiport_loadable_if.sv
// rtl/im_multiport_loadable_if.sv - fetch ports and program loader bundle for im_multiport_loadable
interface im_multiport_loadable_if #(
   parameter int NUM_C  = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 11
);
   logic [NUM_C-1:0]        rd_en;
   logic [NUM_C*ADDR_W-1:0] addr;
   logic [NUM_C*DATA_W-1:0] data_out;
   logic [NUM_C-1:0]        rd_valid;
   logic [NUM_C-1:0]        rd_oor;
   logic                    mem_ready;
   logic                    ld_start;
   logic                    ld_valid;
   logic [DATA_W-1:0]       ld_data;
   logic                    ld_last;
   logic                    ld_ready;
   logic [CNT_W-1:0]        ld_count;
   logic                    ld_ovf;

   modport slave (
      input  rd_en, addr, ld_start, ld_valid, ld_data, ld_last,
      output data_out, rd_valid, rd_oor, mem_ready, ld_ready, ld_count, ld_ovf
   );

   modport master (
      output rd_en, addr, ld_start, ld_valid, ld_data, ld_last,
      input  data_out, rd_valid, rd_oor, mem_ready, ld_ready, ld_count, ld_ovf
   );
endinterface

// File: rtl/im_multiport_loadable.sv
// rtl/im_multiport_loadable.sv - multi-port instruction store, cleared on reset and loaded by a streaming loader
module im_multiport_loadable #(
   parameter int              NUM_C     = 4,
   parameter int              DATA_W    = 16,
   parameter int              ADDR_W    = 16,
   parameter int              DEPTH     = 1024,
   parameter logic [DATA_W-1:0] FILL_WORD = 43,
   parameter int              CNT_W     = $clog2(DEPTH + 1)
) (
   input logic clk,
   input logic rst,
   im_multiport_loadable_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;

   state_t             state, state_nx;
   logic [PTR_W-1:0]   ptr, ptr_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic               ovf_nx;
   logic               we;
   logic [PTR_W-1:0]   wa;
   logic [DATA_W-1:0]  wd;
   logic               rd_go;
   logic               ld_rdy;
   logic [NUM_C-1:0]   port_oor;
   logic [PTR_W-1:0]   port_idx [NUM_C];

   logic [DATA_W-1:0]  mem [DEPTH];

   assign bus.mem_ready = (state == READY);
   assign bus.ld_ready  = ld_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= CLEAR;
         ptr          <= '0;
         bus.ld_count <= '0;
         bus.ld_ovf   <= 1'b0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         bus.ld_count <= cnt_nx;
         bus.ld_ovf   <= ovf_nx;
      end
   end

   // CLEAR and LOAD share the single write port; reads only run in READY.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = bus.ld_count;
      ovf_nx   = bus.ld_ovf;
      we       = 1'b0;
      wa       = ptr;
      wd       = FILL_WORD;
      rd_go    = 1'b0;
      ld_rdy   = 1'b0;
      case (state)
         CLEAR: begin
            we = 1'b1;
            if (ptr == LAST_PTR) begin
               state_nx = READY;
               ptr_nx   = '0;
            end else begin
               ptr_nx = ptr + 1'b1;
            end
         end
         READY: begin
            if (bus.ld_start) begin
               state_nx = LOAD;
               cnt_nx   = '0;
               ovf_nx   = 1'b0;
            end else begin
               rd_go = 1'b1;
            end
         end
         LOAD: begin
            ld_rdy = (bus.ld_count < FULL_CNT);
            if (bus.ld_valid && ld_rdy) begin
               we     = 1'b1;
               wa     = bus.ld_count[PTR_W-1:0];
               wd     = bus.ld_data;
               cnt_nx = bus.ld_count + 1'b1;
               if (bus.ld_last) state_nx = READY;
            end else if (bus.ld_valid) begin
               ovf_nx   = 1'b1;
               state_nx = READY;
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   always_comb begin
      for (int i = 0; i < NUM_C; i++) begin
         port_oor[i] = ({1'b0, bus.addr[i*ADDR_W +: ADDR_W]} >= DEPTH_A);
         port_idx[i] = bus.addr[i*ADDR_W +: PTR_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.data_out <= '0;
         bus.rd_valid <= '0;
         bus.rd_oor   <= '0;
      end else begin
         for (int i = 0; i < NUM_C; i++) begin
            if (rd_go && bus.rd_en[i]) begin
               bus.rd_valid[i] <= 1'b1;
               bus.rd_oor[i]   <= port_oor[i];
               bus.data_out[i*DATA_W +: DATA_W] <= port_oor[i] ? FILL_WORD : mem[port_idx[i]];
            end else begin
               bus.rd_valid[i] <= 1'b0;
               bus.rd_oor[i]   <= 1'b0;
            end
         end
      end
   end
endmodule
